// File: rtl/aes_key_mem.sv
// AES key expansion with a 15-entry round-key memory; borrows the shared
// 4-byte S-box through sboxw/new_sboxw while expanding (ready low).
module aes_key_mem #(
  parameter int unsigned AES_128_NR = 10,
  parameter int unsigned AES_256_NR = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [255:0] key,
  input  logic         keylen,
  input  logic         init,
  input  logic [3:0]   round,
  output logic [127:0] round_key,
  output logic         ready,
  output logic [31:0]  sboxw,
  input  logic [31:0]  new_sboxw
);

  typedef enum logic [1:0] {IDLE, INIT, GEN, DONE} state_e;

  state_e         state_q, state_d;
  logic           ready_q, ready_d;
  logic [255:0]   key_q, key_d;
  logic           keylen_q, keylen_d;
  logic [7:0]     rcon_q, rcon_d;
  logic [3:0]     ctr_q, ctr_d;
  logic [127:0]   mem_q [15];
  logic [127:0]   mem_d [15];

  logic [3:0]     nr;
  logic [3:0]     base_idx;
  logic [31:0]    prev_w3;
  logic [127:0]   base_key;
  logic [31:0]    t;
  logic [31:0]    w0, w1, w2, w3;
  logic [7:0]     rcon_next;

  assign nr       = keylen_q ? 4'(AES_256_NR) : 4'(AES_128_NR);
  assign base_idx = keylen_q ? (ctr_q - 4'd2) : (ctr_q - 4'd1);
  assign prev_w3  = mem_q[ctr_q - 4'd1][31:0];
  assign base_key = mem_q[base_idx];

  // AES-256 odd entries use SubWord only; everything else RotWord+SubWord+rcon
  assign t = (keylen_q && ctr_q[0]) ? new_sboxw
                                    : ({new_sboxw[23:0], new_sboxw[31:24]} ^ {rcon_q, 24'h0});
  assign w0 = base_key[127:96] ^ t;
  assign w1 = base_key[95:64]  ^ w0;
  assign w2 = base_key[63:32]  ^ w1;
  assign w3 = base_key[31:0]   ^ w2;
  assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    key_d    = key_q;
    keylen_d = keylen_q;
    rcon_d   = rcon_q;
    ctr_d    = ctr_q;
    mem_d    = mem_q;
    sboxw    = '0;
    case (state_q)
      IDLE: begin
        if (init) begin
          key_d    = key;
          keylen_d = keylen;
          ready_d  = 1'b0;
          state_d  = INIT;
        end
      end
      INIT: begin
        mem_d[0] = key_q[255:128];
        if (keylen_q) mem_d[1] = key_q[127:0];
        ctr_d   = keylen_q ? 4'd2 : 4'd1;
        rcon_d  = 8'h01;
        state_d = GEN;
      end
      GEN: begin
        sboxw        = prev_w3;
        mem_d[ctr_q] = {w0, w1, w2, w3};
        if (!keylen_q || !ctr_q[0]) rcon_d = rcon_next;
        ctr_d = ctr_q + 4'd1;
        if (ctr_q == nr) state_d = DONE;
      end
      DONE: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      key_q    <= '0;
      keylen_q <= 1'b0;
      rcon_q   <= 8'h01;
      ctr_q    <= '0;
      for (int unsigned i = 0; i < 15; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      key_q    <= key_d;
      keylen_q <= keylen_d;
      rcon_q   <= rcon_d;
      ctr_q    <= ctr_d;
      mem_q    <= mem_d;
    end
  end

  assign ready     = ready_q;
  assign round_key = (round > nr) ? '0 : mem_q[round];

endmodule

// File: tb/tb_aes_key_mem.sv
// Directed bench for aes_key_mem with a behavioural S-box on sboxw/new_sboxw.
module tb_aes_key_mem;

  logic         clk = 1'b0;
  logic         reset;
  logic [255:0] key;
  logic         keylen;
  logic         init;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic         ready;
  logic [31:0]  sboxw;
  logic [31:0]  new_sboxw;

  int vectors = 0;
  int miscompares = 0;
  int low;

  logic [0:255][7:0] sbox_tbl;

  localparam logic [255:0] K128A = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K128B = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K256  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  aes_key_mem #(.AES_128_NR(10), .AES_256_NR(14)) dut (
    .clk(clk), .reset(reset), .key(key), .keylen(keylen), .init(init),
    .round(round), .round_key(round_key), .ready(ready),
    .sboxw(sboxw), .new_sboxw(new_sboxw)
  );

  always #5 clk = ~clk;

  assign new_sboxw = {sbox_tbl[sboxw[31:24]], sbox_tbl[sboxw[23:16]],
                      sbox_tbl[sboxw[15:8]],  sbox_tbl[sboxw[7:0]]};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [3:0] r, input string tag, input logic [127:0] exp);
    @(negedge clk);
    round = r;
    #1;
    check(tag, round_key, exp);
  endtask

  // Accept init, optionally re-pulse init (with a bogus key) after repulse_at
  // low cycles, and count cycles with ready low (bounded).
  task automatic expand(input logic [255:0] k, input logic kl, input int repulse_at,
                        output int low_cycles);
    @(negedge clk);
    key = k; keylen = kl; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    low_cycles = 0;
    while (ready !== 1'b1 && low_cycles < 40) begin
      low_cycles++;
      if (low_cycles == repulse_at) begin
        init = 1'b1; key = ~k; keylen = ~kl;
      end else begin
        init = 1'b0;
      end
      @(posedge clk); #1;
    end
    init = 1'b0;
    key = ~k;
    keylen = ~kl;
  endtask

  initial begin
    sbox_tbl = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    reset = 1'b1; key = '0; keylen = 1'b0; init = 1'b0; round = '0;
    #2;
    check("reset_ready", {127'h0, ready}, 128'h1);
    check("reset_rk0", round_key, '0);
    check("reset_sboxw", {96'h0, sboxw}, '0);
    #20 reset = 1'b0;

    // AES-128 FIPS-197 C.1 key
    expand(K128A, 1'b0, 0, low);
    check("a128_low_cycles", 128'(low), 128'd12);
    check("a128_idle_sboxw", {96'h0, sboxw}, '0);
    rd(4'd0,  "a128_r0",  128'h000102030405060708090a0b0c0d0e0f);
    rd(4'd10, "a128_r10", 128'h13111d7fe3944a17f307a78b4d2b30c5);
    rd(4'd11, "a128_r11", '0);

    // AES-128 FIPS-197 A.1 key
    expand(K128B, 1'b0, 0, low);
    check("b128_low_cycles", 128'(low), 128'd12);
    rd(4'd1,  "b128_r1",  128'ha0fafe1788542cb123a339392a6c7605);
    rd(4'd10, "b128_r10", 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-256 FIPS-197 C.3 key
    expand(K256, 1'b1, 0, low);
    check("a256_low_cycles", 128'(low), 128'd15);
    check("a256_idle_sboxw", {96'h0, sboxw}, '0);
    rd(4'd0,  "a256_r0",  128'h000102030405060708090a0b0c0d0e0f);
    rd(4'd1,  "a256_r1",  128'h101112131415161718191a1b1c1d1e1f);
    rd(4'd14, "a256_r14", 128'h24fc79ccbf0979e9371ac23c6d68de36);
    rd(4'd15, "a256_r15", '0);

    // Back-to-back AES-128 after AES-256: stale upper entries masked
    expand(K128A, 1'b0, 0, low);
    check("seq_low_cycles", 128'(low), 128'd12);
    check("seq_idle_sboxw", {96'h0, sboxw}, '0);
    rd(4'd0,  "seq_r0",  128'h000102030405060708090a0b0c0d0e0f);
    rd(4'd10, "seq_r10", 128'h13111d7fe3944a17f307a78b4d2b30c5);
    for (int i = 11; i < 15; i++) rd(4'(i), "seq_masked", '0);

    // Re-pulsed init mid-expansion is ignored
    expand(K128A, 1'b0, 5, low);
    check("repulse_low_cycles", 128'(low), 128'd12);
    rd(4'd0,  "repulse_r0",  128'h000102030405060708090a0b0c0d0e0f);
    rd(4'd10, "repulse_r10", 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Reset in the middle of an AES-256 expansion
    @(negedge clk);
    round = 4'd0; key = K256; keylen = 1'b1; init = 1'b1;
    @(posedge clk); #1;
    init = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("mid_ready_low", {127'h0, ready}, 128'h0);
    reset = 1'b1;
    #1;
    check("rst_async_ready", {127'h0, ready}, 128'h1);
    check("rst_async_rk0", round_key, '0);
    for (int i = 0; i < 16; i++) rd(4'(i), "rst_cleared", '0);
    @(negedge clk);
    reset = 1'b0;

    expand(K128A, 1'b0, 0, low);
    check("post_rst_low_cycles", 128'(low), 128'd12);
    rd(4'd0,  "post_rst_r0",  128'h000102030405060708090a0b0c0d0e0f);
    rd(4'd10, "post_rst_r10", 128'h13111d7fe3944a17f307a78b4d2b30c5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
